// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CNN datapath: walks a small config table and runs the
// conv or max-pool engine once per layer, chaining output dims into the next layer.
module cnn_layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int TIMEOUT    = 1048576,
  localparam int LW  = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int WDW = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    num_layers,
  input  logic [9:0]    img_w,
  input  logic [9:0]    img_h,
  input  logic          cfg_wr,
  input  logic [LW-1:0] cfg_layer,
  input  logic          cfg_op,
  input  logic [4:0]    cfg_kernel,
  input  logic [4:0]    cfg_stride,
  input  logic          conv_done,
  input  logic          maxpool_done,
  input  logic [9:0]    res_width,
  input  logic [9:0]    res_height,
  output logic [9:0]    w1,
  output logic [9:0]    h1,
  output logic [4:0]    w2,
  output logic [4:0]    h2,
  output logic [4:0]    stride,
  output logic          conv_enable,
  output logic          maxpool_enable,
  output logic          engine_clear,
  output logic          buf_sel,
  output logic [LW-1:0] layer_idx,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  state_t         r_state;
  logic           r_op     [MAX_LAYERS];
  logic [4:0]     r_kernel [MAX_LAYERS];
  logic [4:0]     r_stride [MAX_LAYERS];
  logic [9:0]     r_cur_w;
  logic [9:0]     r_cur_h;
  logic [2:0]     r_num_layers;
  logic [WDW-1:0] r_wd;

  logic       w_cfg_ok;
  logic       w_op;
  logic [4:0] w_kernel;
  logic [4:0] w_stride;
  logic       w_sel_done;
  logic       w_load_bad;
  logic       w_last;
  logic       w_nl_bad;

  assign w_cfg_ok   = cfg_wr && !busy && (int'(cfg_layer) < MAX_LAYERS);
  assign w_op       = r_op[layer_idx];
  assign w_kernel   = r_kernel[layer_idx];
  assign w_stride   = r_stride[layer_idx];
  assign w_sel_done = w_op ? maxpool_done : conv_done;
  assign w_load_bad = (w_kernel == '0) || (w_stride == '0) ||
                      ({5'b0, w_kernel} > r_cur_w) || ({5'b0, w_kernel} > r_cur_h);
  assign w_last     = (int'(layer_idx) == int'(r_num_layers) - 1);
  assign w_nl_bad   = (num_layers == '0) || (int'(num_layers) > MAX_LAYERS);

  // Table write shares the start edge, so an entry written alongside start is seen by LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        r_op[i]     <= 1'b0;
        r_kernel[i] <= '0;
        r_stride[i] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_op[cfg_layer]     <= cfg_op;
      r_kernel[cfg_layer] <= cfg_kernel;
      r_stride[cfg_layer] <= cfg_stride;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cur_w        <= '0;
      r_cur_h        <= '0;
      r_num_layers   <= '0;
      r_wd           <= '0;
      w1             <= '0;
      h1             <= '0;
      w2             <= '0;
      h2             <= '0;
      stride         <= '0;
      conv_enable    <= 1'b0;
      maxpool_enable <= 1'b0;
      engine_clear   <= 1'b0;
      buf_sel        <= 1'b0;
      layer_idx      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      engine_clear <= 1'b0;
      done         <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_num_layers <= num_layers;
            r_cur_w      <= img_w;
            r_cur_h      <= img_h;
            layer_idx    <= '0;
            if (w_nl_bad) begin
              error   <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_ERR;
            end else begin
              error   <= 1'b0;
              busy    <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w1     <= r_cur_w;
          h1     <= r_cur_h;
          w2     <= w_kernel;
          h2     <= w_kernel;
          stride <= w_stride;
          if (w_load_bad) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_ERR;
          end else begin
            engine_clear <= 1'b1;
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_wd           <= '0;
          conv_enable    <= !w_op;
          maxpool_enable <= w_op;
          r_state        <= S_RUN;
        end
        S_RUN: begin
          if (w_sel_done) begin
            conv_enable    <= 1'b0;
            maxpool_enable <= 1'b0;
            r_cur_w        <= res_width;
            r_cur_h        <= res_height;
            r_state        <= S_CAPTURE;
          end else if (r_wd == WDW'(TIMEOUT - 1)) begin
            conv_enable    <= 1'b0;
            maxpool_enable <= 1'b0;
            error          <= 1'b1;
            busy           <= 1'b0;
            r_state        <= S_ERR;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        S_CAPTURE: begin
          buf_sel <= ~buf_sel;
          if (r_cur_w == '0 || r_cur_h == '0) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_ERR;
          end else if (w_last) begin
            w1      <= r_cur_w;
            h1      <= r_cur_h;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            layer_idx <= layer_idx + LW'(1);
            r_state   <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed and randomized passes for cnn_layer_sequencer, checked against a
// layer-by-layer arithmetic model of the network pass and the engine.
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  logic reset, start, cfg_wr, cfg_op, conv_done, maxpool_done;
  logic [2:0] num_layers;
  logic [9:0] img_w, img_h, res_width, res_height;
  logic [1:0] cfg_layer;
  logic [4:0] cfg_kernel, cfg_stride;

  logic [9:0] w1, h1;
  logic [4:0] w2, h2, stride;
  logic conv_enable, maxpool_enable, engine_clear, buf_sel, busy, done, error;
  logic [1:0] layer_idx;

  logic [9:0] wd_w1, wd_h1;
  logic [4:0] wd_w2, wd_h2, wd_stride;
  logic wd_conv_enable, wd_maxpool_enable, wd_engine_clear, wd_buf_sel, wd_busy, wd_done, wd_error;
  logic [1:0] wd_layer_idx;

  cnn_layer_sequencer #(.MAX_LAYERS(4), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
    .img_w(img_w), .img_h(img_h), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer),
    .cfg_op(cfg_op), .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .conv_done(conv_done), .maxpool_done(maxpool_done),
    .res_width(res_width), .res_height(res_height),
    .w1(w1), .h1(h1), .w2(w2), .h2(h2), .stride(stride),
    .conv_enable(conv_enable), .maxpool_enable(maxpool_enable),
    .engine_clear(engine_clear), .buf_sel(buf_sel), .layer_idx(layer_idx),
    .busy(busy), .done(done), .error(error)
  );

  cnn_layer_sequencer #(.MAX_LAYERS(4), .TIMEOUT(16)) dut_wd (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
    .img_w(img_w), .img_h(img_h), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer),
    .cfg_op(cfg_op), .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .conv_done(conv_done), .maxpool_done(maxpool_done),
    .res_width(res_width), .res_height(res_height),
    .w1(wd_w1), .h1(wd_h1), .w2(wd_w2), .h2(wd_h2), .stride(wd_stride),
    .conv_enable(wd_conv_enable), .maxpool_enable(wd_maxpool_enable),
    .engine_clear(wd_engine_clear), .buf_sel(wd_buf_sel), .layer_idx(wd_layer_idx),
    .busy(wd_busy), .done(wd_done), .error(wd_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int m_op[4];
  int m_k[4];
  int m_s[4];
  bit m_buf;
  bit pw_en;
  int pw_idx, pw_op, pw_k, pw_s;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int idx, input int op, input int k, input int s);
    cfg_wr     = 1'b1;
    cfg_layer  = idx[1:0];
    cfg_op     = op[0];
    cfg_kernel = 5'(k);
    cfg_stride = 5'(s);
    tick;
    cfg_wr = 1'b0;
    m_op[idx] = op;
    m_k[idx]  = k;
    m_s[idx]  = s;
  endtask

  task automatic do_pass(input int nl, input int iw, input int ih,
                         input int minlat, input int maxlat, input bit inject);
    int cw, ch, k, s, op, rw, rh, lat;
    cw = iw;
    ch = ih;
    num_layers = 3'(nl);
    img_w = 10'(iw);
    img_h = 10'(ih);
    start = 1'b1;
    if (pw_en) begin
      cfg_wr     = 1'b1;
      cfg_layer  = pw_idx[1:0];
      cfg_op     = pw_op[0];
      cfg_kernel = 5'(pw_k);
      cfg_stride = 5'(pw_s);
      m_op[pw_idx] = pw_op;
      m_k[pw_idx]  = pw_k;
      m_s[pw_idx]  = pw_s;
      pw_en = 1'b0;
    end
    tick;
    start  = 1'b0;
    cfg_wr = 1'b0;
    if (nl < 1 || nl > 4) begin
      chk("badnl_err", error, 1);
      chk("badnl_busy", busy, 0);
      chk("badnl_idx", layer_idx, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_err", error, 0);
    for (int i = 0; i < nl; i++) begin
      k  = m_k[i];
      s  = m_s[i];
      op = m_op[i];
      tick;
      if (k == 0 || s == 0 || k > cw || k > ch) begin
        chk("load_err", error, 1);
        chk("load_busy", busy, 0);
        chk("load_idx", layer_idx, i);
        chk("load_en", {conv_enable, maxpool_enable}, 0);
        chk("load_buf", buf_sel, m_buf);
        return;
      end
      chk("clr_pulse", engine_clear, 1);
      chk("clr_en", {conv_enable, maxpool_enable}, 0);
      chk("clr_idx", layer_idx, i);
      tick;
      chk("run_clr", engine_clear, 0);
      chk("run_en", {conv_enable, maxpool_enable}, (op != 0) ? 2'b01 : 2'b10);
      chk("run_geom", {w1, h1, w2, h2, stride}, {10'(cw), 10'(ch), 5'(k), 5'(k), 5'(s)});
      rw  = (cw - k) / s + 1;
      rh  = (ch - k) / s + 1;
      lat = $urandom_range(maxlat, minlat);
      for (int c = 1; c < lat; c++) begin
        if (op != 0) conv_done = 1'($urandom_range(1, 0));
        else maxpool_done = 1'($urandom_range(1, 0));
        res_width  = 10'($urandom_range(1023, 0));
        res_height = 10'($urandom_range(1023, 0));
        if (inject && c == 1) begin
          cfg_wr     = 1'b1;
          cfg_layer  = i[1:0];
          cfg_op     = 1'($urandom_range(1, 0));
          cfg_kernel = 5'($urandom_range(31, 0));
          cfg_stride = 5'($urandom_range(31, 0));
          start      = 1'b1;
          img_w      = 10'($urandom_range(1023, 0));
        end
        tick;
        cfg_wr = 1'b0;
        start  = 1'b0;
      end
      chk("run_hold", {conv_enable, maxpool_enable, w1, w2, stride},
          {((op != 0) ? 2'b01 : 2'b10), 10'(cw), 5'(k), 5'(s)});
      conv_done    = (op == 0);
      maxpool_done = (op != 0);
      res_width    = 10'(rw);
      res_height   = 10'(rh);
      tick;
      conv_done    = 1'b0;
      maxpool_done = 1'b0;
      res_width    = 10'($urandom_range(1023, 0));
      res_height   = 10'($urandom_range(1023, 0));
      chk("cap_en", {conv_enable, maxpool_enable}, 0);
      chk("cap_busy", busy, 1);
      m_buf = ~m_buf;
      cw = rw;
      ch = rh;
      tick;
      chk("cap_buf", buf_sel, m_buf);
      if (i == nl - 1) begin
        chk("done_pulse", done, 1);
        chk("done_dims", {w1, h1}, {10'(cw), 10'(ch)});
        chk("done_busy", busy, 0);
        chk("done_idx", layer_idx, i);
        tick;
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
      end else begin
        chk("next_idx", layer_idx, i + 1);
        chk("next_done", done, 0);
        chk("next_busy", busy, 1);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; cfg_wr = 1'b0; cfg_op = 1'b0; cfg_layer = '0;
    cfg_kernel = '0; cfg_stride = '0; conv_done = 1'b0; maxpool_done = 1'b0;
    num_layers = '0; img_w = '0; img_h = '0; res_width = '0; res_height = '0;
    pw_en = 1'b0; m_buf = 1'b0;
    for (int i = 0; i < 4; i++) begin m_op[i] = 0; m_k[i] = 0; m_s[i] = 0; end
    #1;
    chk("reset_outs", {w1, h1, w2, h2, stride, conv_enable, maxpool_enable, engine_clear,
                       buf_sel, layer_idx, busy, done, error}, 0);
    tick;
    reset = 1'b1;
    tick;

    // Single maxpool layer, 28x28 -> 14x14 after 50 cycles
    cfg(0, 1, 2, 2);
    do_pass(1, 28, 28, 50, 50, 1'b0);

    // Three-layer chain 32 -> 28 -> 14 -> 12
    cfg(0, 0, 5, 1);
    cfg(1, 1, 2, 2);
    cfg(2, 0, 3, 1);
    do_pass(3, 32, 32, 2, 12, 1'b0);

    // Kernel larger than image, then a legal start recovers
    cfg(0, 0, 5, 1);
    do_pass(1, 4, 4, 2, 5, 1'b0);
    cfg(0, 1, 2, 2);
    do_pass(1, 4, 4, 2, 5, 1'b0);

    do_pass(0, 16, 16, 2, 5, 1'b0);
    do_pass(5, 16, 16, 2, 5, 1'b0);
    do_pass(4, 1, 1, 2, 5, 1'b0);

    // Config write and start during RUN are ignored; rerun shows the table intact
    cfg(0, 0, 5, 1);
    cfg(1, 1, 2, 2);
    cfg(2, 0, 3, 1);
    do_pass(3, 32, 32, 3, 10, 1'b1);
    do_pass(3, 32, 32, 2, 6, 1'b0);

    pw_en = 1'b1; pw_idx = 0; pw_op = 0; pw_k = 3; pw_s = 1;
    do_pass(1, 20, 20, 2, 6, 1'b0);

    repeat (12) begin
      for (int i = 0; i < 4; i++)
        cfg(i, $urandom_range(1, 0), $urandom_range(5, 0), $urandom_range(3, 1));
      do_pass($urandom_range(4, 1), $urandom_range(40, 6), $urandom_range(40, 6), 1, 20, 1'b0);
    end

    repeat (100) tick;

    // Watchdog on the TIMEOUT=16 instance; engines never answer
    cfg(0, 0, 3, 1);
    num_layers = 3'd1; img_w = 10'd10; img_h = 10'd10; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("wd_run_en", wd_conv_enable, 1);
    repeat (15) tick;
    chk("wd_edge_err", {wd_error, wd_conv_enable, wd_busy}, 3'b011);
    tick;
    chk("wd_timeout", {wd_error, wd_conv_enable, wd_maxpool_enable, wd_busy}, 4'b1000);
    chk("main_still_run", {conv_enable, busy, error}, 3'b110);

    // Reset mid-RUN clears everything without a clock edge
    reset = 1'b0;
    #1;
    chk("rst_main", {w1, h1, w2, h2, stride, conv_enable, maxpool_enable, engine_clear,
                     buf_sel, layer_idx, busy, done, error}, 0);
    chk("rst_wd", {wd_w1, wd_h1, wd_w2, wd_h2, wd_stride, wd_conv_enable, wd_maxpool_enable,
                   wd_engine_clear, wd_buf_sel, wd_layer_idx, wd_busy, wd_done, wd_error}, 0);
    m_buf = 1'b0;
    for (int i = 0; i < 4; i++) begin m_op[i] = 0; m_k[i] = 0; m_s[i] = 0; end
    tick;
    reset = 1'b1;
    tick;
    chk("post_rst_idle", {busy, error, done}, 0);
    do_pass(1, 10, 10, 2, 5, 1'b0);
    cfg(0, 1, 2, 2);
    do_pass(1, 10, 10, 2, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
